// File: rtl/dside_pkg.sv
// Shared types for the data-side store buffer: access-size codes and the
// layout of one buffered store.
package dside_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } stb_entry_t;

    localparam int STB_ENTRY_W = 70;

endpackage

// File: rtl/stb_fifo.sv
// Store-entry FIFO with a combinational head; push is ignored when full and
// pop is ignored when empty.
module stb_fifo
    import dside_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = STB_ENTRY_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dside_store_buffer.sv
// Posted-write buffer between the core data port and the bridge: stores are
// acked locally and drained in order; loads wait until every store is gone.
module dside_store_buffer
    import dside_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_WR_INFLIGHT = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        in_req,
    input  logic        in_wr,
    input  logic [1:0]  in_size,
    input  logic [31:0] in_addr,
    input  logic [3:0]  in_wstrb,
    input  logic [31:0] in_wdata,
    output logic        in_addr_ok,
    output logic        in_data_ok,
    output logic [31:0] in_rdata,
    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [31:0] out_addr,
    output logic [3:0]  out_wstrb,
    output logic [31:0] out_wdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok,
    input  logic [31:0] out_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(MAX_WR_INFLIGHT + 1);

    logic [IW-1:0] r_wr_inflight;
    logic          r_rd_outstanding;
    logic          r_store_ack_q;

    stb_entry_t    w_push_entry;
    stb_entry_t    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    logic w_drain;
    logic w_ld_allow;
    logic w_ld_req;
    logic w_st_accept;
    logic w_ld_accept;
    logic w_pop;
    logic w_wr_done;
    logic w_rd_done;

    assign w_push_entry = {in_size, in_addr, in_wstrb, in_wdata};

    stb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (STB_ENTRY_W)
    ) u_fifo (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_push      (w_st_accept),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign w_drain     = ~w_empty & (r_wr_inflight < IW'(MAX_WR_INFLIGHT));
    assign w_ld_allow  = w_empty & (r_wr_inflight == '0) & ~r_rd_outstanding & ~r_store_ack_q;
    assign w_ld_req    = w_ld_allow & in_req & ~in_wr;
    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign w_st_accept = in_req & in_wr & ~w_full & ~r_rd_outstanding;
    assign w_ld_accept = w_ld_req & out_addr_ok;
    assign w_pop       = w_drain & out_addr_ok;
    assign w_wr_done   = out_data_ok & (r_wr_inflight != '0);
    assign w_rd_done   = out_data_ok & r_rd_outstanding;

    // Every output is forced low while reset is held, independent of inputs.
    always_comb begin
        in_addr_ok = 1'b0;
        in_data_ok = 1'b0;
        in_rdata   = '0;
        out_req    = 1'b0;
        out_wr     = 1'b0;
        out_size   = '0;
        out_addr   = '0;
        out_wstrb  = '0;
        out_wdata  = '0;
        if (aresetn) begin
            in_addr_ok = w_st_accept | w_ld_accept;
            in_data_ok = r_store_ack_q | w_rd_done;
            in_rdata   = w_rd_done ? out_rdata : '0;
            if (w_drain) begin
                out_req   = 1'b1;
                out_wr    = 1'b1;
                out_size  = w_head.size;
                out_addr  = w_head.addr;
                out_wstrb = w_head.wstrb;
                out_wdata = w_head.wdata;
            end else if (w_ld_req) begin
                out_req   = 1'b1;
                out_wr    = 1'b0;
                out_size  = in_size;
                out_addr  = in_addr;
                out_wstrb = in_wstrb;
                out_wdata = in_wdata;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_inflight    <= '0;
            r_rd_outstanding <= 1'b0;
            r_store_ack_q    <= 1'b0;
        end else begin
            r_store_ack_q <= w_st_accept;
            if (w_ld_accept) begin
                r_rd_outstanding <= 1'b1;
            end else if (w_rd_done) begin
                r_rd_outstanding <= 1'b0;
            end
            case ({w_pop, w_wr_done})
                2'b10:   r_wr_inflight <= r_wr_inflight + 1'b1;
                2'b01:   r_wr_inflight <= r_wr_inflight - 1'b1;
                default: r_wr_inflight <= r_wr_inflight;
            endcase
        end
    end

    a_no_orphan_data_ok : assert property (@(posedge aclk) disable iff (!aresetn)
        !(out_data_ok && !r_rd_outstanding && (r_wr_inflight == '0)));

endmodule

// File: tb/tb_dside_store_buffer.sv
// Directed bench for dside_store_buffer: a bridge model answers requests with
// programmable latency; monitors compare bridge requests and core responses
// against queues filled when stimulus is issued.
module tb_dside_store_buffer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_req, in_wr;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [3:0]  in_wstrb;
    logic        in_addr_ok, in_data_ok;
    logic [31:0] in_rdata;
    logic        out_req, out_wr;
    logic [1:0]  out_size;
    logic [31:0] out_addr, out_wdata;
    logic [3:0]  out_wstrb;
    logic        out_addr_ok;
    logic        out_data_ok = 1'b0;
    logic [31:0] out_rdata = 32'h0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int wr_lat = 2;
    int rd_lat = 2;

    logic [70:0] exp_out[$];
    logic [31:0] exp_resp[$];
    int          br_due[$];
    logic [31:0] br_data[$];

    dside_store_buffer #(.DEPTH(4), .MAX_WR_INFLIGHT(2)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_req(in_req), .in_wr(in_wr), .in_size(in_size), .in_addr(in_addr),
        .in_wstrb(in_wstrb), .in_wdata(in_wdata),
        .in_addr_ok(in_addr_ok), .in_data_ok(in_data_ok), .in_rdata(in_rdata),
        .out_req(out_req), .out_wr(out_wr), .out_size(out_size), .out_addr(out_addr),
        .out_wstrb(out_wstrb), .out_wdata(out_wdata),
        .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok), .out_rdata(out_rdata)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge aclk) cyc = cyc + 1;

    // Bridge response driver: one response per cycle, in acceptance order.
    always @(posedge aclk) begin
        #1;
        if (aresetn && br_due.size() > 0 && br_due[0] <= cyc) begin
            out_data_ok = 1'b1;
            out_rdata   = br_data[0];
            void'(br_due.pop_front());
            void'(br_data.pop_front());
        end else begin
            out_data_ok = 1'b0;
            out_rdata   = 32'h0;
        end
    end

    // Bridge request monitor.
    always @(negedge aclk) begin
        if (aresetn && out_req && out_addr_ok) begin
            if (exp_out.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_bridge_req: got addr %h wr %b, expected none", out_addr, out_wr);
            end else begin
                check("bridge_req", {out_wr, out_size, out_addr, out_wstrb, out_wdata}, exp_out.pop_front());
            end
            br_due.push_back(cyc + (out_wr ? wr_lat : rd_lat));
            br_data.push_back(out_wr ? 32'h0 : rd_model(out_addr));
        end
    end

    // Core response monitor.
    always @(negedge aclk) begin
        if (aresetn && in_data_ok) begin
            if (exp_resp.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_core_resp: got rdata %h, expected none", in_rdata);
            end else begin
                check("core_resp", in_rdata, exp_resp.pop_front());
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] d, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        exp_out.push_back({wr, sz, a, st, d});
        exp_resp.push_back(wr ? 32'h0 : rd_model(a));
        in_req = 1'b1; in_wr = wr; in_size = sz; in_addr = a; in_wstrb = st; in_wdata = d;
        while (!ok && waited < 300) begin
            @(negedge aclk);
            if (in_addr_ok) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL accept_timeout: addr %h not accepted after %0d cycles, required accept", a, waited);
        end
        @(posedge aclk);
        #1;
        in_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 400) begin
            @(negedge aclk);
            if (exp_out.size() == 0 && exp_resp.size() == 0 && br_due.size() == 0 &&
                !out_req && !in_data_ok && dut.r_wr_inflight == 0)
                done = 1'b1;
            else
                n++;
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL %s_idle_timeout: got busy after %0d cycles, required idle", name, n);
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int w;
        int w5;
        in_req = 1'b1; in_wr = 1'b0; in_size = 2'd2; in_addr = 32'h1C00_0000;
        in_wstrb = 4'hF; in_wdata = 32'h0; out_addr_ok = 1'b1;
        #2;
        check("reset_outputs", {in_addr_ok, in_data_ok, in_rdata, out_req, out_wr, out_size,
                                out_addr, out_wstrb, out_wdata}, 128'h0);
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        in_req = 1'b0;
        @(posedge aclk);
        #1;

        // Single store
        wr_lat = 2;
        issue(1'b1, 2'd2, 32'h1C00_0010, 4'hF, 32'hDEAD_BEEF, w);
        check("t1_accept_wait", w, 0);
        @(negedge aclk);
        check("t1_ack_next", in_data_ok, 1'b1);
        check("t1_out_req", {out_req, out_wr, out_size, out_addr, out_wstrb, out_wdata},
              {1'b1, 1'b1, 2'd2, 32'h1C00_0010, 4'hF, 32'hDEAD_BEEF});
        wait_idle("t1");
        check("t1_inflight_zero", dut.r_wr_inflight, 0);

        // Fill with the bridge stalled
        out_addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 2'd2, 32'h1C00_0100 + 32'(i * 4), 4'hF, 32'h1111_0000 + 32'(i), w);
            check("t2_accept_wait", w, 0);
        end
        fork
            issue(1'b1, 2'd2, 32'h1C00_0110, 4'hF, 32'h1111_0004, w5);
            begin
                repeat (5) @(posedge aclk);
                #1;
                out_addr_ok = 1'b1;
            end
        join
        check("t2_fifth_stall", w5, 6);
        wait_idle("t2");

        // Store then load, slow write response
        wr_lat = 5;
        rd_lat = 3;
        issue(1'b1, 2'd2, 32'h1C00_0020, 4'hF, 32'hCAFE_F00D, w);
        check("t3_store_wait", w, 0);
        issue(1'b0, 2'd2, 32'h1C00_0020, 4'h0, 32'h0, w);
        check("t3_load_wait", w, 6);
        wait_idle("t3");

        // Load then store, slow read response
        wr_lat = 2;
        rd_lat = 4;
        issue(1'b0, 2'd2, 32'h1C00_0040, 4'h0, 32'h0, w);
        check("t4_load_wait", w, 0);
        issue(1'b1, 2'd2, 32'h1C00_0044, 4'hF, 32'h1234_5678, w);
        check("t4_store_wait", w, 4);
        wait_idle("t4");

        // Reset with queued and in-flight stores
        out_addr_ok = 1'b0;
        wr_lat = 20;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 2'd2, 32'h1C00_0200 + 32'(i * 4), 4'hF, 32'hA0A0_0000 + 32'(i), w);
        end
        @(negedge aclk);
        @(posedge aclk);
        #1;
        out_addr_ok = 1'b1;
        @(posedge aclk);
        #1;
        out_addr_ok = 1'b0;
        check("t5_pre_state", {dut.w_count, dut.r_wr_inflight}, {3'd3, 2'd1});
        #1;
        aresetn = 1'b0;
        in_req = 1'b1; in_wr = 1'b1; out_addr_ok = 1'b1;
        #1;
        check("t5_reset_outputs", {in_addr_ok, in_data_ok, in_rdata, out_req, out_wr, out_size,
                                   out_addr, out_wstrb, out_wdata}, 128'h0);
        exp_out.delete();
        exp_resp.delete();
        br_due.delete();
        br_data.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        in_req = 1'b0;
        wr_lat = 2;
        rd_lat = 2;
        @(negedge aclk);
        check("t5_count_after", {dut.w_count, out_req}, {3'd0, 1'b0});
        @(posedge aclk);
        #1;
        issue(1'b0, 2'd2, 32'h1C00_0300, 4'h0, 32'h0, w);
        check("t5_load_wait", w, 0);
        wait_idle("t5");

        // Byte store
        issue(1'b1, 2'd0, 32'h1C00_0012, 4'h4, 32'h00AB_0000, w);
        check("t6_accept_wait", w, 0);
        @(negedge aclk);
        check("t6_out_fields", {out_req, out_size, out_wstrb, out_wdata},
              {1'b1, 2'd0, 4'h4, 32'h00AB_0000});
        wait_idle("t6");

        check("final_exp_out_empty", exp_out.size(), 0);
        check("final_exp_resp_empty", exp_resp.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
